// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state type and result/flag types for the pipelined ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_XNOR = 4'b1001;
  localparam logic [3:0] OP_EQ   = 4'b1010;
  localparam logic [3:0] OP_GT   = 4'b1011;
  localparam logic [3:0] OP_LT   = 4'b1100;
  localparam logic [3:0] OP_SHR  = 4'b1101;
  localparam logic [3:0] OP_SHL  = 4'b1110;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  localparam int CMP_EQ = 1;
  localparam int CMP_GT = 2;
  localparam int CMP_LT = 3;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_e;

  typedef struct packed {
    logic arith;
    logic logic_op;
    logic cmp;
    logic shift;
    logic carry;
    logic div0;
  } flags_t;

endpackage

// File: rtl/alu_serial_div.sv
// Radix-2 restoring unsigned divider: one quotient bit per cycle, WIDTH cycles per divide.
module alu_serial_div #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH:0]   rem_sh, diff;

  // diff's top bit is the borrow: clear means the shifted remainder covers the divisor
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    if (busy_q) begin
      rem_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH-1)) busy_d = 1'b0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      quo_d  = a;
      dvs_d  = b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == CW'(WIDTH-1));
  assign quotient = quo_q;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked WIDTH-bit ALU: single-cycle ops register in one edge, divide runs serially.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_FUN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             Arith_Flag,
  output logic             Logic_Flag,
  output logic             CMP_Flag,
  output logic             Shift_Flag,
  output logic             Carry_Flag,
  output logic             Div0_Flag
);
  localparam int DIV_CYC = WIDTH;

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   alu_out_q, alu_out_d;
  flags_t             flags_q, flags_d;

  logic               slot_free, accept, div_iter, div_busy, div_done;
  logic [WIDTH-1:0]   div_quo, res;
  flags_t             fl;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == IDLE) && slot_free && !rst;
  assign accept    = in_valid && in_ready;
  assign div_iter  = (ALU_FUN == OP_DIV) && (B != '0);

  alu_serial_div #(.WIDTH(DIV_CYC)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (accept && div_iter),
    .a        (A),
    .b        (B),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  assign sum  = {1'b0, A} + {1'b0, B};
  assign prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  always_comb begin
    res = '0;
    fl  = '0;
    case (ALU_FUN)
      OP_ADD:  begin res = sum[WIDTH-1:0]; fl.arith = 1'b1; fl.carry = sum[WIDTH]; end
      OP_SUB:  begin res = A - B; fl.arith = 1'b1; fl.carry = (A < B); end
      OP_MUL:  begin res = prod[WIDTH-1:0]; fl.arith = 1'b1; fl.carry = |prod[2*WIDTH-1:WIDTH]; end
      // only reaches the output register when B==0; nonzero B goes to the divider
      OP_DIV:  begin res = '1; fl.arith = 1'b1; fl.div0 = 1'b1; end
      OP_AND:  begin res = A & B;    fl.logic_op = 1'b1; end
      OP_OR:   begin res = A | B;    fl.logic_op = 1'b1; end
      OP_NAND: begin res = ~(A & B); fl.logic_op = 1'b1; end
      OP_NOR:  begin res = ~(A | B); fl.logic_op = 1'b1; end
      OP_XOR:  begin res = A ^ B;    fl.logic_op = 1'b1; end
      OP_XNOR: begin res = ~(A ^ B); fl.logic_op = 1'b1; end
      OP_EQ:   begin res = (A == B) ? WIDTH'(CMP_EQ) : '0; fl.cmp = 1'b1; end
      OP_GT:   begin res = (A >  B) ? WIDTH'(CMP_GT) : '0; fl.cmp = 1'b1; end
      OP_LT:   begin res = (A <  B) ? WIDTH'(CMP_LT) : '0; fl.cmp = 1'b1; end
      OP_SHR:  begin res = A >> 1; fl.shift = 1'b1; end
      OP_SHL:  begin res = A << 1; fl.shift = 1'b1; end
      default: begin res = '0; fl = '0; end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    alu_out_d   = alu_out_q;
    flags_d     = flags_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (div_iter) begin
            state_d = DIV;
          end else begin
            out_valid_d = 1'b1;
            alu_out_d   = res;
            flags_d     = fl;
          end
        end
      end
      DIV: begin
        if (div_done) state_d = DONE;
      end
      DONE: begin
        if (slot_free && !div_busy) begin
          out_valid_d    = 1'b1;
          alu_out_d      = div_quo;
          flags_d        = '0;
          flags_d.arith  = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign ALU_OUT    = alu_out_q;
  assign Arith_Flag = flags_q.arith;
  assign Logic_Flag = flags_q.logic_op;
  assign CMP_Flag   = flags_q.cmp;
  assign Shift_Flag = flags_q.shift;
  assign Carry_Flag = flags_q.carry;
  assign Div0_Flag  = flags_q.div0;

endmodule
